// File: rtl/hazard_branch_unit.sv
// hazard_branch_unit: RAW scoreboard stall, static branch prediction with
// execute redirect, and an N-deep lookback buffer of return PC/PSW.
// Optional: define STALL_COUNT_EN for a saturating stall-cycle counter;
// without it stall_cnt is tied to 0.
module hazard_branch_unit #(
  parameter int REG_CNT      = 8,
  parameter int DEP_STAGES   = 2,
  parameter int PC_W         = 16,
  parameter int OFF_W        = 13,
  parameter int PSW_W        = 16,
  parameter int LB_DEPTH     = 2,
  parameter int PREDICT_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_CNT-1:0]  dep_set,
  input  logic [REG_CNT-1:0]  dep_use,
  input  logic                flush,
  output logic [REG_CNT-1:0]  stall,
  output logic                stall_any,
  input  logic                fetch_en,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [2:0]          opc_msb,
  input  logic [OFF_W-1:0]    br_off,
  input  logic [PSW_W-1:0]    psw_in,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic [PC_W-1:0]     pc_next,
  output logic                pred_taken,
  output logic [PC_W-1:0]     lb_pc_lr,
  output logic [PSW_W-1:0]    lb_psw_lr,
  output logic [PC_W-1:0]     lb_pc,
  output logic [PSW_W-1:0]    lb_psw,
  output logic [LB_DEPTH-1:0] lb_valid,
  output logic [15:0]         stall_cnt
);

  logic [DEP_STAGES-1:0][REG_CNT-1:0] dep;
  logic [REG_CNT-1:0]                 dep_or;

  // Union of every pending write still in flight
  always_comb begin
    dep_or = '0;
    for (int k = 0; k < DEP_STAGES; k++) dep_or = dep_or | dep[k];
  end

  // A flush kills the producers, so no hit can be reported that cycle
  assign stall     = flush ? '0 : (dep_or & dep_use);
  assign stall_any = |stall;

  // Scoreboard chain; a stalled decode inserts a bubble instead of its write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dep <= '0;
    end else if (flush) begin
      dep <= '0;
    end else begin
      for (int k = DEP_STAGES - 1; k > 0; k--) dep[k] <= dep[k-1];
      dep[0] <= stall_any ? '0 : dep_set;
    end
  end

  logic signed [OFF_W-1:0] off_s;
  logic [PC_W-1:0]         ext;
  logic [PC_W-1:0]         seq;
  logic                    branch;
  logic                    take;

  assign off_s  = br_off;
  assign ext    = PC_W'(off_s) << 1;
  assign seq    = pc_in + PC_W'(2);
  assign branch = (opc_msb == 3'b000) || (opc_msb == 3'b001);
  assign take   = (PREDICT_MODE == 0) ? branch : (branch & br_off[OFF_W-1]);

  // Next fetch PC: reset, then redirect, then hold on stall/no-fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_next    <= '0;
      pred_taken <= 1'b0;
    end else if (redirect_valid) begin
      pc_next    <= redirect_pc;
      pred_taken <= 1'b0;
    end else if (fetch_en && !stall_any) begin
      pc_next    <= take ? (seq + ext) : seq;
      pred_taken <= take;
    end
  end

  logic [LB_DEPTH-1:0][PC_W-1:0]  lb_pc_q;
  logic [LB_DEPTH-1:0][PSW_W-1:0] lb_psw_q;
  logic                           advance;

  assign advance = fetch_en & ~stall_any & ~redirect_valid;

  // Lookback shift register; redirect only invalidates, data is left stale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lb_pc_q  <= '0;
      lb_psw_q <= '0;
      lb_valid <= '0;
    end else if (redirect_valid) begin
      lb_valid <= '0;
    end else if (advance) begin
      for (int k = LB_DEPTH - 1; k > 0; k--) begin
        lb_pc_q[k]  <= lb_pc_q[k-1];
        lb_psw_q[k] <= lb_psw_q[k-1];
        lb_valid[k] <= lb_valid[k-1];
      end
      lb_pc_q[0]  <= seq;
      lb_psw_q[0] <= psw_in;
      lb_valid[0] <= 1'b1;
    end
  end

  assign lb_pc_lr  = lb_pc_q[0];
  assign lb_psw_lr = lb_psw_q[0];
  assign lb_pc     = lb_pc_q[LB_DEPTH-1];
  assign lb_psw    = lb_psw_q[LB_DEPTH-1];

`ifdef STALL_COUNT_EN
  logic [15:0] cnt;

  // Saturating stall counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (stall_any && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_branch_unit.sv
// Randomized + directed bench for hazard_branch_unit against a queue-based
// reference model.
module tb_hazard_branch_unit;
  localparam int REG_CNT = 8, DEP_STAGES = 2, PC_W = 16, OFF_W = 13;
  localparam int PSW_W = 16, LB_DEPTH = 2, PREDICT_MODE = 1;

  logic clk = 0, rst_n = 0, flush = 0, fetch_en = 0, redirect_valid = 0;
  logic [REG_CNT-1:0] dep_set = 0, dep_use = 0, stall;
  logic stall_any, pred_taken;
  logic [PC_W-1:0] pc_in = 0, redirect_pc = 0, pc_next, lb_pc_lr, lb_pc;
  logic [2:0] opc_msb = 3'b100;
  logic [OFF_W-1:0] br_off = 0;
  logic [PSW_W-1:0] psw_in = 0, lb_psw_lr, lb_psw;
  logic [LB_DEPTH-1:0] lb_valid;
  logic [15:0] stall_cnt;

  hazard_branch_unit #(.REG_CNT(REG_CNT), .DEP_STAGES(DEP_STAGES), .PC_W(PC_W),
    .OFF_W(OFF_W), .PSW_W(PSW_W), .LB_DEPTH(LB_DEPTH), .PREDICT_MODE(PREDICT_MODE))
  dut (.clk(clk), .rst_n(rst_n), .dep_set(dep_set), .dep_use(dep_use), .flush(flush),
    .stall(stall), .stall_any(stall_any), .fetch_en(fetch_en), .pc_in(pc_in),
    .opc_msb(opc_msb), .br_off(br_off), .psw_in(psw_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_next(pc_next), .pred_taken(pred_taken),
    .lb_pc_lr(lb_pc_lr), .lb_psw_lr(lb_psw_lr), .lb_pc(lb_pc), .lb_psw(lb_psw),
    .lb_valid(lb_valid), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", tag, act, exp);
  endtask

  // Reference model: in-flight writes by age, PC/prediction, lookback list
  logic [REG_CNT-1:0] m_pend[$];
  logic [PC_W-1:0]    m_pc;
  logic               m_pt;
  logic [PC_W-1:0]    m_lbpc[$];
  logic [PSW_W-1:0]   m_lbpsw[$];
  int                 m_nv;
  int                 m_cnt;

  function automatic logic [REG_CNT-1:0] m_stall();
    logic [REG_CNT-1:0] s = 0;
    if (flush) return 0;
    foreach (m_pend[i]) s |= m_pend[i] & dep_use;
    return s;
  endfunction

  task automatic m_update();
    logic [REG_CNT-1:0] s = m_stall();
    int off, seq, tgt;
    bit br, tk;
    off = int'(br_off);
    if (br_off[OFF_W-1]) off -= (1 << OFF_W);
    seq = (int'(pc_in) + 2) % (1 << PC_W);
    tgt = (seq + 2 * off + (1 << (PC_W + 2))) % (1 << PC_W);
    br  = (opc_msb < 3'd2);
    tk  = (PREDICT_MODE == 0) ? br : (br && off < 0);
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_pc = 0; m_pt = 0; m_nv = 0; m_cnt = 0;
      foreach (m_lbpc[i]) begin m_lbpc[i] = 0; m_lbpsw[i] = 0; end
    end else begin
      if (s != 0 && m_cnt < 16'hFFFF) m_cnt++;
      if (flush) foreach (m_pend[i]) m_pend[i] = 0;
      else begin
        m_pend.push_front(s != 0 ? '0 : dep_set);
        void'(m_pend.pop_back());
      end
      if (redirect_valid) begin
        m_pc = redirect_pc; m_pt = 0; m_nv = 0;
      end else if (fetch_en && s == 0) begin
        m_pc = tk ? PC_W'(tgt) : PC_W'(seq); m_pt = tk;
        m_lbpc.push_front(PC_W'(seq)); void'(m_lbpc.pop_back());
        m_lbpsw.push_front(psw_in);    void'(m_lbpsw.pop_back());
        if (m_nv < LB_DEPTH) m_nv++;
      end
    end
  endtask

  // One cycle: inputs already driven after a negedge
  task automatic step();
    logic [REG_CNT-1:0] es;
    #1;
    es = m_stall();
    chk("stall", stall, es);
    chk("stall_any", stall_any, es != 0);
    m_update();
    @(posedge clk); #1;
    chk("pc_next", pc_next, m_pc);
    chk("pred_taken", pred_taken, m_pt);
    chk("lb_valid", lb_valid, (1 << m_nv) - 1);
    if (m_nv >= 1) begin
      chk("lb_pc_lr", lb_pc_lr, m_lbpc[0]);
      chk("lb_psw_lr", lb_psw_lr, m_lbpsw[0]);
    end
    if (m_nv == LB_DEPTH) begin
      chk("lb_pc", lb_pc, m_lbpc[LB_DEPTH-1]);
      chk("lb_psw", lb_psw, m_lbpsw[LB_DEPTH-1]);
    end
`ifdef STALL_COUNT_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`else
    chk("stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEP_STAGES; i++) m_pend.push_back(0);
    for (int i = 0; i < LB_DEPTH; i++) begin m_lbpc.push_back(0); m_lbpsw.push_back(0); end
    m_pc = 0; m_pt = 0; m_nv = 0; m_cnt = 0;
    @(negedge clk);

    // Reset defaults
    rst_n = 0; step(); step();
    chk("rst_pc", pc_next, 0); chk("rst_lbv", lb_valid, 0);
    chk("rst_stall", stall, 0); chk("rst_pt", pred_taken, 0);

    // RAW held for DEP_STAGES cycles
    rst_n = 1; dep_set = 8'h04; step();
    dep_set = 0; dep_use = 8'h04; #1 chk("raw_c1", stall, 8'h04); step();
    #1 chk("raw_c2", stall, 8'h04); step();
    #1 chk("raw_rel", stall, 8'h00); step();
    dep_set = 8'h04; dep_use = 0; step();
    dep_set = 0; dep_use = 8'h02; #1 chk("raw_other", stall, 8'h00); step();
    dep_use = 0; step(); step();

    // Prediction, backward taken / forward not taken
    fetch_en = 1; pc_in = 16'h0100; opc_msb = 3'b000; br_off = 13'h1FFE; step();
    chk("pred_bwd_pc", pc_next, 16'h00FE); chk("pred_bwd_t", pred_taken, 1);
    br_off = 13'h0004; step();
    chk("pred_fwd_pc", pc_next, 16'h0102); chk("pred_fwd_t", pred_taken, 0);

    // Redirect wins over stall
    fetch_en = 0; opc_msb = 3'b100; dep_set = 8'h01; step();
    dep_set = 0; dep_use = 8'h01; fetch_en = 1; redirect_valid = 1; redirect_pc = 16'h2000;
    #1 chk("redir_stall", stall_any, 1); step();
    chk("redir_pc", pc_next, 16'h2000); chk("redir_lbv", lb_valid, 0);
    redirect_valid = 0; dep_use = 0; fetch_en = 0;

    // Flush kills dependency
    dep_set = 8'h01; step();
    dep_set = 0; dep_use = 8'h01; flush = 1; #1 chk("flush_now", stall, 0); step();
    flush = 0; #1 chk("flush_after", stall, 0); step();
    dep_use = 0;

    // Lookback shift and PC wrap
    fetch_en = 1; opc_msb = 3'b100; pc_in = 16'hFFFE; psw_in = 16'h1111; step();
    pc_in = 16'h0010; psw_in = 16'h2222; step();
    chk("lb_wrap_pc", lb_pc, 16'h0000); chk("lb_wrap_lr", lb_pc_lr, 16'h0012);
    chk("lb_wrap_v", lb_valid, 2'b11);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = PC_W'($urandom);
      fetch_en = ($urandom_range(0, 3) != 0);
      dep_set  = ($urandom_range(0, 1) != 0) ? REG_CNT'(1 << $urandom_range(0, REG_CNT-1)) : '0;
      dep_use  = REG_CNT'($urandom) & REG_CNT'($urandom);
      pc_in    = PC_W'($urandom);
      opc_msb  = 3'($urandom);
      br_off   = OFF_W'($urandom);
      psw_in   = PSW_W'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
